m_fetch_sequencer: RTL and testbench
====================================

// Module: m_fetch_sequencer
// PURPOSE
//  Multi-cycle fetch controller that sequences the program counter register.
//  Each cycle it produces pc_update/pc_sel for the PC register and drives the
//  instruction-memory request handshake. It hands fetched words to decode over a
//  valid/ready link and squashes fetches overtaken by branch/jump redirects.
//  A no-response timeout forces the PC to the panic vector.
// PARAMETERS
//  TIMEOUT_CYCLES  default 16  FETCH cycles without imem_ack before panic (>=2)
//  TMO_W           default 5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  pc_in            in   32  current PC from the PC register
//  imem_req         out  1   fetch request, held high until imem_ack
//  imem_addr        out  32  fetch address, equals pc_in while imem_req=1
//  imem_ack         in   1   memory response strobe, one cycle, qualifies imem_rdata
//  imem_rdata       in   32  fetched instruction word
//  instr_valid      out  1   instr holds a valid instruction for decode
//  instr            out  32  captured instruction word
//  instr_ready      in   1   decode accepts instr this cycle
//  redirect_branch  in   1   execute resolved a taken branch (1-cycle pulse)
//  redirect_jump    in   1   execute resolved a jump (1-cycle pulse)
//  pc_update        out  1   PC register advances this edge
//  pc_sel           out  2   00 seq(+4), 01 branch, 10 jump, 11 panic
//  panic_out        out  1   1-cycle pulse when a timeout panic is issued
// BEHAVIOUR
//  - Reset (synchronous): state=FETCH, imem_req=0, instr_valid=0, instr=0,
//    pc_update=0, pc_sel=00, panic_out=0, pending=none, timeout count=0.
//    The first imem_req is raised the cycle after reset deasserts.
//  - FETCH state:
//    - imem_req=1 and imem_addr=pc_in. Count increments each cycle without ack.
//    - ack with a redirect pending, or with a redirect arriving the same cycle:
//      drop the word (squash) and go to UPDATE with the redirect select.
//    - ack with no redirect: instr<=imem_rdata and go to HOLD.
//      Ack-to-instr_valid latency is 1 cycle.
//    - Count reaches TIMEOUT_CYCLES-1 with no ack: go to UPDATE with sel=11 and
//      pulse panic_out. A late ack after this is ignored.
//  - HOLD state:
//    - instr_valid=1; instr is stable until accepted.
//    - instr_ready=1 with no redirect: go to UPDATE with sel=00.
//    - A redirect (live or pending) takes priority: instr_valid drops next cycle,
//      the word is not consumed, and the block goes to UPDATE with the redirect sel.
//  - UPDATE state:
//    - pc_update=1 for exactly 1 cycle with pc_sel from the latched select.
//    - Then clear that select and count, and return to FETCH.
//    - pc_sel=00 whenever pc_update=0.
//  - Redirect latch:
//    - branch and jump in the same cycle record branch.
//    - The first recorded redirect holds; later pulses are ignored until consumed.
//    - A redirect arriving in UPDATE is recorded and consumed at the end of the
//      next FETCH, and that fetched word is squashed.
//  - A redirect arriving in the panic UPDATE cycle is discarded, because panic
//    flushes the pipe.
//  - Reset asserted in any state returns everything to reset values on that edge.
//    An outstanding ack is ignored.
//  - Minimum instruction period is 3 cycles: FETCH (ack in the first cycle),
//    HOLD (ready), UPDATE.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    - adds outputs perf_fetch_cnt[31:0] (words delivered to decode) and
//      perf_squash_cnt[31:0] (words squashed or redirected away).
//    - Both are cleared by reset and wrap modulo 2^32.
//  FETCH_PERF_CNT_EN undefined:
//    - those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, pc_in=0, ack 1 cycle after req, rdata=0x12345678, ready=1 ->
//     instr_valid with 0x12345678, then pc_update=1 with pc_sel=00, next
//     imem_addr = new pc_in.
//  2. imem_req held, no ack for 16 cycles -> panic_out=1, pc_update=1 with
//     pc_sel=11; an ack at cycle 17 is ignored and the next req uses pc_in=0x0ffffff0.
//  3. redirect_branch pulse during FETCH, ack 2 cycles later -> no instr_valid,
//     pc_update=1 with pc_sel=01, then a new request.
//  4. In HOLD with instr_ready=0, pulse redirect_jump -> instr_valid falls,
//     pc_update=1 with pc_sel=10.
//  5. redirect_branch and redirect_jump in the same cycle -> pc_sel=01.
//  6. Assert reset in HOLD -> next cycle instr_valid=0, imem_req=0,
//     pc_update=0; after release, req resumes.

Source files
------------

// File: rtl/m_fetch_sequencer.sv
// m_fetch_sequencer: multi-cycle fetch controller driving the PC register.
// Cycles FETCH -> HOLD -> UPDATE, squashes words that a branch or jump
// redirect has overtaken, and forces the panic vector when memory stays
// silent for too long.
// Optional build macro: FETCH_PERF_CNT_EN adds delivered/squashed word counters.
module m_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        redirect_branch,
  input  logic        redirect_jump,
  output logic        pc_update,
  output logic [1:0]  pc_sel,
  output logic        panic_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt
`endif
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam logic [1:0] SEL_SEQ   = 2'b00;
  localparam logic [1:0] SEL_BR    = 2'b01;
  localparam logic [1:0] SEL_JMP   = 2'b10;
  localparam logic [1:0] SEL_PANIC = 2'b11;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_nx;
  logic             pend_vld;
  logic             pend_vld_nx;
  logic [1:0]       pend_sel;
  logic [1:0]       pend_sel_nx;
  logic [1:0]       sel_nx;
  logic             panic_nx;
  logic             capture;
  logic             deliver;
  logic             squash;

  // Live redirect decode: branch wins when both pulse together.
  logic       live_redir;
  logic [1:0] live_sel;
  logic       redir_any;
  logic [1:0] redir_sel;
  logic       rec_vld;
  logic [1:0] rec_sel;

  assign live_redir = redirect_branch | redirect_jump;
  assign live_sel   = redirect_branch ? SEL_BR : SEL_JMP;
  assign redir_any  = pend_vld | live_redir;
  assign redir_sel  = pend_vld ? pend_sel : live_sel;
  // First recorded redirect holds; later pulses are dropped until consumed.
  assign rec_vld    = pend_vld | live_redir;
  assign rec_sel    = pend_vld ? pend_sel : live_sel;

  assign imem_addr  = imem_req ? pc_in : 32'h0000_0000;

  // Next-state, redirect latch and timeout decisions for the fetch sequence.
  always_comb begin
    state_nx    = state;
    tmo_cnt_nx  = tmo_cnt;
    pend_vld_nx = pend_vld;
    pend_sel_nx = pend_sel;
    sel_nx      = SEL_SEQ;
    panic_nx    = 1'b0;
    capture     = 1'b0;
    deliver     = 1'b0;
    squash      = 1'b0;
    case (state)
      ST_FETCH: begin
        if (imem_req) begin
          if (imem_ack) begin
            if (redir_any) begin
              state_nx    = ST_UPDATE;
              sel_nx      = redir_sel;
              pend_vld_nx = 1'b0;
              pend_sel_nx = SEL_SEQ;
              squash      = 1'b1;
            end else begin
              state_nx = ST_HOLD;
              capture  = 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Panic flushes everything, including any recorded redirect.
            state_nx    = ST_UPDATE;
            sel_nx      = SEL_PANIC;
            panic_nx    = 1'b1;
            pend_vld_nx = 1'b0;
            pend_sel_nx = SEL_SEQ;
          end else begin
            tmo_cnt_nx  = tmo_cnt + TMO_W'(1);
            pend_vld_nx = rec_vld;
            pend_sel_nx = rec_sel;
          end
        end else begin
          // First cycle after reset: request not yet raised.
          pend_vld_nx = rec_vld;
          pend_sel_nx = rec_sel;
        end
      end
      ST_HOLD: begin
        if (redir_any) begin
          state_nx    = ST_UPDATE;
          sel_nx      = redir_sel;
          pend_vld_nx = 1'b0;
          pend_sel_nx = SEL_SEQ;
          squash      = 1'b1;
        end else if (instr_ready) begin
          state_nx = ST_UPDATE;
          sel_nx   = SEL_SEQ;
          deliver  = 1'b1;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      ST_UPDATE: begin
        state_nx   = ST_FETCH;
        tmo_cnt_nx = '0;
        if (pc_sel == SEL_PANIC) begin
          pend_vld_nx = 1'b0;
          pend_sel_nx = SEL_SEQ;
        end else begin
          pend_vld_nx = rec_vld;
          pend_sel_nx = rec_sel;
        end
      end
      default: begin
        state_nx   = ST_FETCH;
        tmo_cnt_nx = '0;
      end
    endcase
  end

  // State registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      tmo_cnt     <= '0;
      pend_vld    <= 1'b0;
      pend_sel    <= SEL_SEQ;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      pc_update   <= 1'b0;
      pc_sel      <= SEL_SEQ;
      panic_out   <= 1'b0;
    end else begin
      state       <= state_nx;
      tmo_cnt     <= tmo_cnt_nx;
      pend_vld    <= pend_vld_nx;
      pend_sel    <= pend_sel_nx;
      imem_req    <= (state_nx == ST_FETCH);
      instr_valid <= (state_nx == ST_HOLD);
      pc_update   <= (state_nx == ST_UPDATE);
      pc_sel      <= (state_nx == ST_UPDATE) ? sel_nx : SEL_SEQ;
      panic_out   <= panic_nx;
      if (capture) begin
        instr <= imem_rdata;
      end else begin
        instr <= instr;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Delivered and squashed word counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= 32'd0;
      perf_squash_cnt <= 32'd0;
    end else begin
      perf_fetch_cnt  <= perf_fetch_cnt + {31'd0, deliver};
      perf_squash_cnt <= perf_squash_cnt + {31'd0, squash};
    end
  end
`endif

endmodule

// File: tb/tb_m_fetch_sequencer.sv
// Self-checking bench for m_fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_m_fetch_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        redirect_branch;
  logic        redirect_jump;
  logic        pc_update;
  logic [1:0]  pc_sel;
  logic        panic_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  m_fetch_sequencer #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .redirect_branch(redirect_branch), .redirect_jump(redirect_jump),
    .pc_update(pc_update), .pc_sel(pc_sel), .panic_out(panic_out)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_squash_cnt(perf_squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase is tracked as which kind of cycle comes next.
  bit          m_req, m_valid, m_upd, m_panic;
  int          m_sel;
  logic [31:0] m_instr;
  int          wait_n;
  int          pend_q[$];
  logic [31:0] m_fetched, m_squashed;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit ack, input bit rdy,
                            input bit br, input bit jp, input logic [31:0] rdata);
    int live;
    int sel;
    live = br ? 1 : (jp ? 2 : 0);
    if (rst) begin
      m_req = 0; m_valid = 0; m_upd = 0; m_panic = 0; m_sel = 0;
      m_instr = 32'h0; wait_n = 0; pend_q.delete();
      m_fetched = 32'd0; m_squashed = 32'd0;
    end else begin
      m_panic = 0;
      if (m_upd) begin
        if (m_sel != 3 && live != 0 && pend_q.size() == 0) pend_q.push_back(live);
        m_upd = 0; m_sel = 0; m_req = 1; wait_n = 0;
      end else if (m_req) begin
        if (ack) begin
          sel = (pend_q.size() != 0) ? pend_q[0] : live;
          pend_q.delete();
          m_req = 0;
          if (sel != 0) begin
            m_upd = 1; m_sel = sel; m_squashed++;
          end else begin
            m_valid = 1; m_instr = rdata;
          end
        end else if (wait_n == TMO - 1) begin
          pend_q.delete();
          m_req = 0; m_upd = 1; m_sel = 3; m_panic = 1;
        end else begin
          wait_n++;
          if (live != 0 && pend_q.size() == 0) pend_q.push_back(live);
        end
      end else if (m_valid) begin
        sel = (pend_q.size() != 0) ? pend_q[0] : live;
        if (sel != 0) begin
          pend_q.delete();
          m_valid = 0; m_upd = 1; m_sel = sel; m_squashed++;
        end else if (rdy) begin
          m_valid = 0; m_upd = 1; m_sel = 0; m_fetched++;
        end
      end else begin
        if (live != 0 && pend_q.size() == 0) pend_q.push_back(live);
        m_req = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit rst, input bit ack, input bit rdy, input bit br,
                      input bit jp, input logic [31:0] rdata, input logic [31:0] pc);
    @(negedge clk);
    reset = rst; imem_ack = ack; instr_ready = rdy;
    redirect_branch = br; redirect_jump = jp;
    imem_rdata = rdata; pc_in = pc;
    model_step(rst, ack, rdy, br, jp, rdata);
    @(posedge clk);
    #1;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) check_eq("imem_addr", imem_addr, pc_in);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check_eq("instr", instr, m_instr);
    check_eq("pc_update", {31'd0, pc_update}, {31'd0, m_upd});
    check_eq("pc_sel", {30'd0, pc_sel}, 32'(m_sel));
    check_eq("panic_out", {31'd0, panic_out}, {31'd0, m_panic});
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_fetched);
    check_eq("perf_squash", perf_squash_cnt, m_squashed);
`endif
  endtask

  initial begin
    int ack_pct;
    int red_pct;
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect_branch = 1'b0;
    redirect_jump = 1'b0; imem_rdata = 32'h0; pc_in = 32'h0;

    // Scenario 1: reset, single fetch, accept, sequential update.
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_upd", {31'd0, pc_update}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("t1_req", {31'd0, imem_req}, 32'd1);
    step(0, 1, 0, 0, 0, 32'h1234_5678, 32'h0);
    check_eq("t1_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("t1_instr", instr, 32'h1234_5678);
    step(0, 0, 1, 0, 0, 32'h0, 32'h0);
    check_eq("t1_upd", {30'd0, pc_sel, pc_update}, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h4);
    check_eq("t1_addr", imem_addr, 32'h4);

    // Scenario 2: silent memory for the full timeout, late ack ignored.
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h4);
    check_eq("t2_wait", {31'd0, panic_out}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h4);
    check_eq("t2_panic", {31'd0, panic_out}, 32'd1);
    check_eq("t2_sel", {30'd0, pc_sel}, 32'd3);
    step(0, 1, 0, 0, 0, 32'hbad0_bad0, 32'h0fff_fff0);
    check_eq("t2_addr", imem_addr, 32'h0fff_fff0);
    check_eq("t2_novalid", {31'd0, instr_valid}, 32'd0);

    // Scenario 3: branch during FETCH, ack two cycles later is squashed.
    step(0, 0, 0, 1, 0, 32'h0, 32'h100);
    step(0, 0, 0, 0, 0, 32'h0, 32'h100);
    step(0, 1, 0, 0, 0, 32'hdead_beef, 32'h100);
    check_eq("t3_sel", {30'd0, pc_sel}, 32'd1);
    check_eq("t3_novalid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h200);

    // Scenario 4: jump while holding an unaccepted word.
    step(0, 1, 0, 0, 0, 32'hcafe_0001, 32'h200);
    step(0, 0, 0, 0, 0, 32'h0, 32'h200);
    step(0, 0, 0, 0, 1, 32'h0, 32'h200);
    check_eq("t4_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t4_sel", {30'd0, pc_sel}, 32'd2);
    step(0, 0, 0, 0, 0, 32'h0, 32'h300);

    // Scenario 5: simultaneous branch and jump select branch.
    step(0, 1, 0, 1, 1, 32'h5555_aaaa, 32'h300);
    check_eq("t5_sel", {30'd0, pc_sel}, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h400);

    // Scenario 6: reset while holding.
    step(0, 1, 0, 0, 0, 32'h7777_0000, 32'h400);
    step(1, 0, 0, 0, 0, 32'h0, 32'h400);
    check_eq("t6_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("t6_req", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0, 32'h400);
    check_eq("t6_resume", {31'd0, imem_req}, 32'd1);

    // Randomized traffic with varying ack and redirect densities.
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 40 : 90);
      red_pct = (blk < 3) ? 5 : 25;
      for (int c = 0; c < 500; c++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < ack_pct),
             ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < red_pct),
             ($urandom_range(0, 99) < red_pct),
             $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
